// File: rtl/elixir_bank_pkg.sv
// Shared types and constants for the elixir bank: fine-unit width and the
// constant divide-by-3 that turns fine units into whole elixir.
package elixir_pkg;

   localparam int unsigned FINE_PER_ELIXIR = 3;
   localparam int unsigned MAX_FINE        = 30;
   localparam int unsigned FINE_W          = 5;
   localparam int unsigned ELI_STEPS       = ((2 ** FINE_W) - 1) / FINE_PER_ELIXIR;

   typedef logic [FINE_W-1:0] fine_t;
   typedef logic [FINE_W:0]   wide_t;

   // Compare chain against constant multiples of 3; no runtime divider.
   function automatic fine_t fine_to_eli(input fine_t f);
      fine_t e;
      e = '0;
      for (int unsigned i = 1; i <= ELI_STEPS; i++) begin
         if (32'(f) >= FINE_PER_ELIXIR * i) e = fine_t'(i);
      end
      return e;
   endfunction

endpackage

// File: rtl/elixir_bank_if.sv
// Spend bus between the card-slot FSMs (master) and the elixir bank (slave).
interface elixir_bank_if;
   import elixir_pkg::*;

   fine_t      elixirin_a;
   fine_t      elixirin_b;
   fine_t      elixirin_c;
   fine_t      elixirin_d;
   logic [3:0] spend_ok;
   logic [3:0] spend_err;
   fine_t      eli;

   modport master (
      output elixirin_a, elixirin_b, elixirin_c, elixirin_d,
      input  spend_ok, spend_err, eli
   );

   modport slave (
      input  elixirin_a, elixirin_b, elixirin_c, elixirin_d,
      output spend_ok, spend_err, eli
   );

endinterface

// File: rtl/elixir_bank_regen_timer.sv
// Regeneration cadence counter: emits a one-cycle tick every terminal count
// while running and below the ceiling.
module regen_timer #(
   parameter int unsigned REGEN_CYCLES = 2_800_000
) (
   input  logic Clk,
   input  logic Reset,
   input  logic run,
   input  logic hold,
   input  logic double_rate,
   output logic tick
);

   localparam int unsigned CW = $clog2(REGEN_CYCLES + 1);
   localparam logic [CW-1:0] LAST_N = CW'(REGEN_CYCLES - 1);
   localparam logic [CW-1:0] LAST_D = CW'((REGEN_CYCLES / 2) - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] last;

   // >= rather than == so a mid-period switch to double rate fires at once.
   always_comb begin
      last = double_rate ? LAST_D : LAST_N;
      tick = run && !hold && (cnt >= last);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt <= '0;
      end else if (hold) begin
         cnt <= '0;
      end else if (run) begin
         if (tick) cnt <= '0;
         else      cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/elixir_bank.sv
// Elixir balance accumulator: arbitrates four spend requests in priority
// order, applies regeneration, and registers fine/eli/full and ack pulses.
module elixir_bank #(
   parameter int unsigned MAX_FINE     = 30,
   parameter int unsigned START_FINE   = 15,
   parameter int unsigned REGEN_CYCLES = 2_800_000
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             run,
   input  logic             double_rate,
   elixir_bank_if.slave     bus,
   output logic [4:0]       fine,
   output logic             full
);
   import elixir_pkg::*;

   fine_t           fine_q;
   fine_t           eli_q;
   logic            full_q;
   logic [3:0]      ok_q;
   logic [3:0]      err_q;

   logic            tick;
   logic            hold;
   logic [3:0][4:0] req;
   wide_t           bal;
   logic [3:0]      ok_n;
   logic [3:0]      err_n;

   assign hold = (fine_q == fine_t'(MAX_FINE));

   regen_timer #(
      .REGEN_CYCLES (REGEN_CYCLES)
   ) u_regen (
      .Clk         (Clk),
      .Reset       (Reset),
      .run         (run),
      .hold        (hold),
      .double_rate (double_rate),
      .tick        (tick)
   );

   // Each lower-priority port sees the balance left after earlier grants.
   always_comb begin
      req[0] = bus.elixirin_a;
      req[1] = bus.elixirin_b;
      req[2] = bus.elixirin_c;
      req[3] = bus.elixirin_d;
      bal    = {1'b0, fine_q};
      ok_n   = '0;
      err_n  = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (req[i] != '0) begin
            if ({1'b0, req[i]} <= bal) begin
               bal     = bal - {1'b0, req[i]};
               ok_n[i] = 1'b1;
            end else begin
               err_n[i] = 1'b1;
            end
         end
      end
      if (tick && (bal < wide_t'(MAX_FINE))) bal = bal + wide_t'(1);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         fine_q <= fine_t'(START_FINE);
         eli_q  <= fine_to_eli(fine_t'(START_FINE));
         full_q <= (START_FINE == MAX_FINE);
         ok_q   <= '0;
         err_q  <= '0;
      end else begin
         fine_q <= bal[4:0];
         eli_q  <= fine_to_eli(bal[4:0]);
         full_q <= (bal == wide_t'(MAX_FINE));
         ok_q   <= ok_n;
         err_q  <= err_n;
      end
   end

   assign fine          = fine_q;
   assign full          = full_q;
   assign bus.eli       = eli_q;
   assign bus.spend_ok  = ok_q;
   assign bus.spend_err = err_q;

endmodule

// File: doc/elixir_bank.md
# elixir_bank

Elixir accumulator feeding the card-deploy FSMs. It holds the player's elixir balance in fine units, three per whole elixir, and regenerates it on a fixed cycle cadence. Each cycle it deducts spend requests from up to four card-slot FSMs and publishes the whole-elixir count `eli` that those FSMs compare against `elixircost / 3`. It is the consuming end of the `elixirin` spend bus.

## Interface
Parameters:
- `MAX_FINE`, 30: balance ceiling in fine units (10 elixir).
- `START_FINE`, 15: balance loaded on reset (5 elixir).
- `REGEN_CYCLES`, 2_800_000: Clk cycles per +1 fine unit at normal rate.

Ports:
- `Clk`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high.
- `run`, in, 1: game active. Low freezes regeneration; spends are still applied.
- `double_rate`, in, 1: halves the regen period (counter terminal becomes `REGEN_CYCLES/2`).
- `elixirin_a`, `elixirin_b`, `elixirin_c`, `elixirin_d`, in, 5 each: spend request in fine units from each card-slot FSM. 0 means no request. A request is nonzero for exactly one cycle.
- `fine`, out, 5: registered balance in fine units, 0..`MAX_FINE`.
- `eli`, out, 5: registered whole elixir, `fine / 3` truncated, 0..10.
- `full`, out, 1: registered, `fine == MAX_FINE`.
- `spend_ok`, out, 4: one-cycle pulse per port {d,c,b,a}. Request was granted and deducted.
- `spend_err`, out, 4: one-cycle pulse per port. Request was rejected for insufficient balance.

## Operation
- Reset values: `fine = START_FINE`, `eli = START_FINE/3`, `full = (START_FINE == MAX_FINE)`. Regen counter = 0. `spend_ok = spend_err = 0`.
- Per-cycle evaluation runs in this order on the current `fine`:
  1. Spends, in priority order a, b, c, d, against a running balance `bal`. For a nonzero request `r`:
     - if `r <= bal`, set `bal -= r` and assert `spend_ok`.
     - otherwise leave `bal` unchanged and assert `spend_err`.
  2. Regen: if a regen tick fires this cycle, `bal = min(bal + 1, MAX_FINE)`.
  3. `fine`, `eli` and `full` all register from the final `bal`.
- Regen counter behaviour:
  - increments while `run == 1` and `fine < MAX_FINE`;
  - fires a tick and clears to 0 when it reaches terminal−1;
  - held at 0 while `fine == MAX_FINE` (start of cycle), so refill begins a full period after the first spend from full;
  - holds its value (no clear) while `run == 0`.
- A `double_rate` change mid-period takes effect immediately. If the counter is already ≥ the new terminal, the tick fires on the next counting cycle and the counter clears.
- Arithmetic is done at 6 bits internally so `bal + 1` and subtractions cannot wrap. Outputs are 5 bits.
- `eli` is computed by a constant divide-by-3 (31-entry LUT or compare chain). No runtime divider.
- A request of 31 (> `MAX_FINE`) always sets `spend_err` for that port.

## Timing
- Spend request at cycle n: `spend_ok`/`spend_err` and the updated `fine`/`eli` are visible at n+1.
- A card FSM that re-checks `eli` at n+1 sees the post-spend value. No stale-window double spend is possible.
- Simultaneous spend and tick in the same cycle: both apply. Net change is −r+1, clamped.
- Simultaneous requests: the lower-priority port is judged against the balance remaining after the higher-priority grants.
- Reset asserted mid-period: all state returns to reset values on the next edge. Any pending request in that cycle is dropped with no ok/err pulse.

## Structure
- Package `elixir_pkg`:
  - `FINE_PER_ELIXIR = 3`, `MAX_FINE = 30`, `FINE_W = 5`;
  - typedef `fine_t` (`logic [4:0]`);
  - function `fine_to_eli`.
- Sub-module `regen_timer`: regen counter with `run`, `hold`, `double_rate` inputs and a `tick` output, parameterized by `REGEN_CYCLES`.
- Top level holds the spend-arbitration combinational chain and the output registers.

## Test plan
- Reset with `START_FINE=15`: `fine=15`, `eli=5`, `full=0`. With `run=1` and `REGEN_CYCLES=4`, `fine` reaches 16 after 4 cycles and `eli` reaches 6 at `fine=18`.
- Fill to 30 → `full=1` and `fine` holds 30. Spend `a=9` → `fine=21`, `spend_ok[0]` for one cycle. The first tick comes exactly `REGEN_CYCLES` cycles later.
- From `fine=10`, same cycle `a=6`, `b=6`, `c=3` → a granted, b `spend_err`, c granted. `fine=1`, `eli=0`.
- Spend `a=3` coincident with a regen tick at `fine=5` → `fine=3`. At `fine=30`, a tick with no spend leaves `fine` at 30.
- `run=0` for 10 cycles mid-period → counter frozen; it resumes with the remaining count. `double_rate=1` → ticks every `REGEN_CYCLES/2`.
- Reset asserted in the same cycle as `a=5` → no ok/err pulse, `fine=15` next cycle.
